// File: rtl/fifo_frame_pkg.sv
// fifo_frame_builder shared types and header layout.
// State encoding, header field offsets and the header packing helper.
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_e;

  localparam int LEN_W        = 16;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_SYNC_LSB = 24;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [31:0] make_hdr(
    input logic [7:0]       sync,
    input logic [7:0]       cnt,
    input logic [LEN_W-1:0] len
  );
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 8]    = sync;
    h[HDR_CNT_LSB +: 8]     = cnt;
    h[HDR_LEN_LSB +: LEN_W] = len;
    return h;
  endfunction

endpackage

// File: rtl/fifo_frame_builder_if.sv
// fifo_frame_builder bus: FIFO read port plus output stream.
// master = frame builder side, slave = FIFO/readout side.
interface fifo_frame_builder_if #(
  parameter int WIDTH = 32
);
  logic             ENABLE;
  logic             FIFO_EMPTY;
  logic             FIFO_RE;
  logic [WIDTH-1:0] FIFO_RDATA;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_FIRST;
  logic             OUT_LAST;
  logic [7:0]       FRAME_CNT;
  logic             BUSY;

  modport master (
    input  ENABLE, FIFO_EMPTY, FIFO_RDATA, OUT_READY,
    output FIFO_RE, OUT_DATA, OUT_VALID, OUT_FIRST,
    output OUT_LAST, FRAME_CNT, BUSY
  );

  modport slave (
    output ENABLE, FIFO_EMPTY, FIFO_RDATA, OUT_READY,
    input  FIFO_RE, OUT_DATA, OUT_VALID, OUT_FIRST,
    input  OUT_LAST, FRAME_CNT, BUSY
  );
endinterface

// File: rtl/fifo_frame_skid.sv
// fifo_frame_skid: small register FIFO catching RAM read data.
// count_o feeds the read-credit calculation in the builder.
module fifo_frame_skid #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // storage, pointers and occupancy; push/pop may coincide
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_frame_builder.sv
// fifo_frame_builder: pops FIFO words, emits header+payload frames.
// Optional checksum trailer when FIFO_FRAME_CHECKSUM_EN is defined.
module fifo_frame_builder
  import fifo_frame_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         FRAME_LEN = 256,
  parameter int         RD_LAT    = 2,
  parameter logic [7:0] SYNC_WORD = SYNC_DEFAULT
) (
  input logic CLOCK,
  input logic RESET_N,
  fifo_frame_builder_if.master bus
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CW1   = CW + 1;
  localparam int FW    = LEN_W + 1;
  localparam logic [FW-1:0] FLEN = FW'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [RD_LAT-1:0] vld_q;
  logic [FW-1:0]    req_q, req_d;
  logic [FW-1:0]    sent_q, sent_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             end_q, end_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] hdr;
  logic [WIDTH-1:0] skid_data;
  logic [CW-1:0]    skid_cnt;
  logic [CW1-1:0]   commit;
  logic             active;
  logic             out_free;
  logic             xfer;
  logic             push;
  logic             pop;
  logic             re;

`ifdef FIFO_FRAME_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
`endif

  assign hdr = WIDTH'(make_hdr(SYNC_WORD, cnt_q,
                               LEN_W'(FRAME_LEN)));

  assign active   = (state_q == HEADER) ||
                    (state_q == PAYLOAD);
  assign out_free = !valid_q || bus.OUT_READY;
  assign xfer     = valid_q && bus.OUT_READY;
  assign push     = vld_q[RD_LAT-1];

  // words held plus words still in the RAM pipeline
  assign commit = CW1'(skid_cnt) +
                  CW1'($countones(vld_q));

  assign pop = active && out_free &&
               (sent_q < FLEN) && (skid_cnt != '0);

  // a pop this cycle frees one slot for a new request
  assign re = active && !bus.FIFO_EMPTY &&
              (req_q < FLEN) &&
              ((commit < CW1'(DEPTH)) || pop);

  fifo_frame_skid #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk_i   (CLOCK),
    .rst_n_i (RESET_N),
    .push_i  (push),
    .data_i  (bus.FIFO_RDATA),
    .pop_i   (pop),
    .data_o  (skid_data),
    .count_o (skid_cnt)
  );

  // read-in-flight tracker: bit RD_LAT-1 marks RDATA valid
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      vld_q <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, re});
    end
  end

  // frame sequencing and output register loading
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sent_d  = sent_q;
    data_d  = data_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    if (re) begin
      req_d = req_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        req_d  = '0;
        sent_d = '0;
        if (bus.ENABLE && !bus.FIFO_EMPTY) begin
          state_d = HEADER;
          data_d  = hdr;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = 1'b0;
          end_d   = 1'b0;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d = PAYLOAD;
          valid_d = 1'b0;
          first_d = 1'b0;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (end_q) begin
            end_d = 1'b0;
`ifdef FIFO_FRAME_CHECKSUM_EN
            state_d = TRAILER;
            data_d  = csum_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            last_d  = 1'b0;
            cnt_d   = cnt_q + 1'b1;
`endif
          end
        end
      end
`ifdef FIFO_FRAME_CHECKSUM_EN
      TRAILER: begin
        if (xfer) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      data_d  = skid_data;
      valid_d = 1'b1;
      first_d = 1'b0;
      sent_d  = sent_q + 1'b1;
      end_d   = (sent_q + 1'b1 == FLEN);
`ifdef FIFO_FRAME_CHECKSUM_EN
      last_d  = 1'b0;
`else
      last_d  = end_d;
`endif
    end
  end

  // state and output registers
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      req_q   <= '0;
      sent_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sent_q  <= sent_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_FRAME_CHECKSUM_EN
  // running XOR of payload words, restarted every header
  always_comb begin
    csum_d = (state_q == HEADER) ? '0 : csum_q;
    if (pop) begin
      csum_d = csum_d ^ skid_data;
    end
  end

  // checksum register
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.FIFO_RE   = re;
  assign bus.OUT_DATA  = data_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_FIRST = first_q;
  assign bus.OUT_LAST  = last_q;
  assign bus.FRAME_CNT = cnt_q;
  assign bus.BUSY      = (state_q != IDLE);

endmodule
